// File: rtl/trng_seed_collector.sv
// trng_seed_collector: pops words from the TRNG, runs the repetition-count
// and adaptive-proportion health tests on every popped word, packs passing
// words into SEED_WIDTH-bit seeds and offers each seed to the DRBG.
//
// Seed handshake: seed_valid is high exactly in PRESENT. seed_data and
// seed_valid hold steady until a clock edge that samples seed_valid &&
// seed_ready; that edge is the transfer. The source side uses a pop-style
// handshake: src_data is consumed on any edge where src_pop is high.
module trng_seed_collector #(
  parameter int WIDTH         = 32,
  parameter int SEED_WIDTH    = 256,
  parameter int STARTUP_WORDS = 4,
  parameter int RCT_CUTOFF    = 4,
  parameter int APT_WINDOW    = 16,
  parameter int APT_CUTOFF    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  src_ready,
  input  logic [WIDTH-1:0]      src_data,
  output logic                  src_pop,
  output logic                  seed_valid,
  input  logic                  seed_ready,
  output logic [SEED_WIDTH-1:0] seed_data,
  output logic                  health_fail,
  input  logic                  clear_fail,
  output logic [7:0]            fail_count,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int WORDS      = SEED_WIDTH / WIDTH;
  localparam int MAX_CNT    = (WORDS > STARTUP_WORDS) ? WORDS : STARTUP_WORDS;
  localparam int CNT_W      = $clog2(MAX_CNT + 1);
  localparam int RCT_W      = $clog2(RCT_CUTOFF + 1);
  localparam int APT_CNT_W  = $clog2(APT_CUTOFF + 1);
  localparam int APT_IDX_W  = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;

  localparam logic [CNT_W-1:0]     WORDS_LAST   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]     STARTUP_LAST = CNT_W'(STARTUP_WORDS - 1);
  localparam logic [RCT_W-1:0]     RCT_LIMIT    = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_CNT_W-1:0] APT_LIMIT    = APT_CNT_W'(APT_CUTOFF);
  localparam logic [APT_IDX_W-1:0] APT_LAST     = APT_IDX_W'(APT_WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_COLLECT = 3'd2,
    S_PRESENT = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       word_cnt;
  logic [RCT_W-1:0]       rct_cnt;
  logic [WIDTH-1:0]       last_word;
  logic [WIDTH-1:0]       apt_ref;
  logic [APT_CNT_W-1:0]   apt_cnt;
  logic [APT_IDX_W-1:0]   apt_idx;

  logic [RCT_W-1:0]       rct_next;
  logic [APT_CNT_W-1:0]   apt_next;
  logic                   health_hit;
  logic                   enter_startup;
  logic                   pack_word;

  // rct_cnt == 0 marks "no previous word since STARTUP entry".
  assign rct_next = (rct_cnt != '0 && src_data == last_word) ? rct_cnt + RCT_W'(1) : RCT_W'(1);
  assign apt_next = (apt_idx == '0) ? APT_CNT_W'(1)
                  : (src_data == apt_ref) ? apt_cnt + APT_CNT_W'(1) : apt_cnt;
  // A word tripping both tests is still a single failure event.
  assign health_hit    = src_pop && ((rct_next >= RCT_LIMIT) || (apt_next >= APT_LIMIT));
  assign enter_startup = (state != S_STARTUP) && (state_next == S_STARTUP);
  assign pack_word     = src_pop && (state == S_COLLECT) &&
                         (state_next == S_COLLECT || state_next == S_PRESENT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a health failure outranks an enable drop on the same word.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (enable) state_next = S_STARTUP;
      S_STARTUP: begin
        if (health_hit)                                    state_next = S_FAIL;
        else if (!enable)                                  state_next = S_IDLE;
        else if (src_pop && word_cnt == STARTUP_LAST)      state_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (health_hit)                                    state_next = S_FAIL;
        else if (!enable)                                  state_next = S_IDLE;
        else if (src_pop && word_cnt == WORDS_LAST)        state_next = S_PRESENT;
      end
      S_PRESENT: if (seed_ready) state_next = enable ? S_COLLECT : S_IDLE;
      S_FAIL:    if (clear_fail) state_next = S_STARTUP;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore outputs plus the pop strobe decoded from state.
  always_comb begin
    src_pop    = src_ready && (state == S_STARTUP || state == S_COLLECT);
    seed_valid = (state == S_PRESENT);
    busy       = (state != S_IDLE);
    state_dbg  = state;
  end

  // Word counter, health-test state and seed shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      rct_cnt   <= '0;
      last_word <= '0;
      apt_ref   <= '0;
      apt_cnt   <= '0;
      apt_idx   <= '0;
      seed_data <= '0;
    end else if (enter_startup) begin
      word_cnt  <= '0;
      rct_cnt   <= '0;
      last_word <= '0;
      apt_ref   <= '0;
      apt_cnt   <= '0;
      apt_idx   <= '0;
    end else if (src_pop) begin
      // Counter restarts whenever the pop moves us to another state.
      word_cnt  <= (state_next != state) ? '0 : word_cnt + CNT_W'(1);
      last_word <= src_data;
      rct_cnt   <= rct_next;
      apt_cnt   <= apt_next;
      if (apt_idx == '0) apt_ref <= src_data;
      apt_idx   <= (apt_idx == APT_LAST) ? '0 : apt_idx + APT_IDX_W'(1);
      if (pack_word) seed_data <= {seed_data[SEED_WIDTH-WIDTH-1:0], src_data};
    end
  end

  // Sticky alarm and saturating failure counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      health_fail <= 1'b0;
      fail_count  <= 8'd0;
    end else if (health_hit) begin
      health_fail <= 1'b1;
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end else if (state == S_FAIL && clear_fail) begin
      health_fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_seed_collector.sv
// Directed testbench for trng_seed_collector. The TRNG is modelled as a
// word queue; the head word is consumed whenever the DUT pops.
module tb_trng_seed_collector;

  localparam int WIDTH      = 32;
  localparam int SEED_WIDTH = 256;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  src_ready = 1'b0;
  logic [WIDTH-1:0]      src_data = '0;
  logic                  src_pop;
  logic                  seed_valid;
  logic                  seed_ready = 1'b0;
  logic [SEED_WIDTH-1:0] seed_data;
  logic                  health_fail;
  logic                  clear_fail = 1'b0;
  logic [7:0]            fail_count;
  logic                  busy;
  logic [2:0]            state_dbg;

  trng_seed_collector dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .src_pop     (src_pop),
    .seed_valid  (seed_valid),
    .seed_ready  (seed_ready),
    .seed_data   (seed_data),
    .health_fail (health_fail),
    .clear_fail  (clear_fail),
    .fail_count  (fail_count),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Stimulus source and scoreboard
  logic [WIDTH-1:0]      src_q[$];
  logic [SEED_WIDTH-1:0] exp_q[$];
  logic                  src_en = 1'b1;
  int                    checks = 0;
  int                    passes = 0;
  logic [7:0]            exp_fail = 8'd0;

  // Driver tasks
  task automatic drive_src();
    src_ready = src_en && (src_q.size() > 0);
    src_data  = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  // One clock: the pop decision seen before the edge retires the head word.
  task automatic step();
    logic p;
    drive_src();
    #1;
    p = src_pop;
    @(posedge clk);
    #1;
    if (p && src_q.size() > 0) src_q.delete(0);
    drive_src();
    #1;
  endtask

  task automatic push_words(input logic [WIDTH-1:0] base, input int n);
    for (int k = 0; k < n; k++) src_q.push_back(base + WIDTH'(k));
  endtask

  // Seed built from words base+1 .. base+8, first word in the MSBs.
  function automatic logic [SEED_WIDTH-1:0] seed_of(input logic [WIDTH-1:0] base);
    logic [SEED_WIDTH-1:0] r;
    r = '0;
    for (int k = 1; k <= 8; k++) r = {r[SEED_WIDTH-WIDTH-1:0], base + WIDTH'(k)};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    src_q.push_back(32'h55);
    repeat (3) step();
    checks++; if (seed_valid !== 1'b0) $display("FAIL reset_seed_valid: got %b want 0", seed_valid); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL reset_seed_data: got %h want 0", seed_data); else passes++;
    checks++; if (health_fail !== 1'b0) $display("FAIL reset_health_fail: got %b want 0", health_fail); else passes++;
    checks++; if (fail_count !== 8'd0) $display("FAIL reset_fail_count: got %0d want 0", fail_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (src_pop !== 1'b0) $display("FAIL reset_src_pop: got %b want 0", src_pop); else passes++;
    rst = 1'b0;
    step();
    checks++; if (state_dbg !== 3'd0) $display("FAIL reset_idle_hold: got %0d want 0", state_dbg); else passes++;
    src_q.delete();
  endtask

  task automatic test_nominal();
    logic [SEED_WIDTH-1:0] exp_seed;
    push_words(32'hA0, 4);
    push_words(32'h1, 8);
    push_words(32'h11, 8);
    exp_q.push_back(256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    exp_q.push_back(seed_of(32'h10));
    enable = 1'b1;
    seed_ready = 1'b0;
    repeat (12) step();
    checks++; if (seed_valid !== 1'b0) $display("FAIL nominal_early_valid: got %b want 0 after 12 cycles", seed_valid); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL nominal_busy: got %b want 1", busy); else passes++;
    step();
    exp_seed = exp_q[0];
    checks++; if (seed_valid !== 1'b1) $display("FAIL nominal_valid_13: got %b want 1", seed_valid); else passes++;
    checks++; if (seed_data !== exp_seed) $display("FAIL nominal_seed: got %h want %h", seed_data, exp_seed); else passes++;
    checks++; if (src_pop !== 1'b0) $display("FAIL nominal_no_pop_present: got %b want 0", src_pop); else passes++;
  endtask

  task automatic test_backpressure();
    logic [SEED_WIDTH-1:0] exp_seed;
    exp_seed = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      clear_fail = (i == 2);
      step();
      checks++; if (seed_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", i, seed_valid); else passes++;
      checks++; if (seed_data !== exp_seed) $display("FAIL bp_stable_%0d: got %h want %h", i, seed_data, exp_seed); else passes++;
      checks++; if (src_pop !== 1'b0) $display("FAIL bp_pop_%0d: got %b want 0", i, src_pop); else passes++;
    end
    clear_fail = 1'b0;
    checks++; if (health_fail !== 1'b0) $display("FAIL bp_clear_ignored: got %b want 0", health_fail); else passes++;
    seed_ready = 1'b1;
    step();
    seed_ready = 1'b0;
    checks++; if (seed_valid !== 1'b0) $display("FAIL bp_after_hs_valid: got %b want 0", seed_valid); else passes++;
    checks++; if (src_pop !== 1'b1) $display("FAIL bp_after_hs_pop: got %b want 1", src_pop); else passes++;
    repeat (7) step();
    checks++; if (seed_valid !== 1'b0) $display("FAIL bp_second_early: got %b want 0", seed_valid); else passes++;
    step();
    exp_seed = exp_q.pop_front();
    checks++; if (seed_valid !== 1'b1) $display("FAIL bp_second_valid: got %b want 1", seed_valid); else passes++;
    checks++; if (seed_data !== exp_seed) $display("FAIL bp_second_seed: got %h want %h", seed_data, exp_seed); else passes++;
    enable = 1'b0;
    seed_ready = 1'b1;
    step();
    seed_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL bp_to_idle: got %b want 0", busy); else passes++;
    src_q.delete();
  endtask

  task automatic test_rct();
    push_words(32'hB0, 4);
    src_q.push_back(32'h21);
    src_q.push_back(32'h22);
    repeat (4) src_q.push_back(32'hDEADBEEF);
    src_q.push_back(32'h99);
    enable = 1'b1;
    repeat (10) step();
    checks++; if (health_fail !== 1'b0) $display("FAIL rct_early: got %b want 0", health_fail); else passes++;
    step();
    exp_fail = 8'd1;
    checks++; if (health_fail !== 1'b1) $display("FAIL rct_alarm: got %b want 1", health_fail); else passes++;
    checks++; if (fail_count !== exp_fail) $display("FAIL rct_count: got %0d want %0d", fail_count, exp_fail); else passes++;
    checks++; if (seed_valid !== 1'b0) $display("FAIL rct_no_seed: got %b want 0", seed_valid); else passes++;
    checks++; if (src_pop !== 1'b0) $display("FAIL rct_no_pop: got %b want 0", src_pop); else passes++;
    step();
    checks++; if (health_fail !== 1'b1) $display("FAIL rct_sticky: got %b want 1", health_fail); else passes++;
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    checks++; if (health_fail !== 1'b0) $display("FAIL rct_cleared: got %b want 0", health_fail); else passes++;
    checks++; if (state_dbg !== 3'd1) $display("FAIL rct_restart_state: got %0d want 1", state_dbg); else passes++;
    checks++; if (fail_count !== exp_fail) $display("FAIL rct_count_hold: got %0d want %0d", fail_count, exp_fail); else passes++;
    checks++; if (src_pop !== 1'b1) $display("FAIL rct_restart_pop: got %b want 1", src_pop); else passes++;
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL rct_to_idle: got %b want 0", busy); else passes++;
    src_q.delete();
  endtask

  task automatic test_apt();
    logic [SEED_WIDTH-1:0] exp_seed;
    for (int pos = 1; pos <= 15; pos++)
      src_q.push_back((pos % 2 == 1) ? 32'h5A5A5A5A : 32'h100 + WIDTH'(pos / 2 - 1));
    src_q.push_back(32'h777);
    exp_seed = 256'h5A5A5A5A_00000102_5A5A5A5A_00000103_5A5A5A5A_00000104_5A5A5A5A_00000105;
    enable = 1'b1;
    seed_ready = 1'b1;
    repeat (13) step();
    checks++; if (seed_valid !== 1'b1) $display("FAIL apt_seed_valid: got %b want 1", seed_valid); else passes++;
    checks++; if (seed_data !== exp_seed) $display("FAIL apt_seed: got %h want %h", seed_data, exp_seed); else passes++;
    step();
    repeat (2) step();
    checks++; if (health_fail !== 1'b0) $display("FAIL apt_early_14: got %b want 0", health_fail); else passes++;
    step();
    exp_fail = 8'd2;
    checks++; if (health_fail !== 1'b1) $display("FAIL apt_alarm_15: got %b want 1", health_fail); else passes++;
    checks++; if (fail_count !== exp_fail) $display("FAIL apt_count: got %0d want %0d", fail_count, exp_fail); else passes++;
    checks++; if (src_pop !== 1'b0) $display("FAIL apt_no_pop: got %b want 0", src_pop); else passes++;
    seed_ready = 1'b0;
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL apt_to_idle: got %b want 0", busy); else passes++;
    src_q.delete();
  endtask

  task automatic test_enable_drop();
    logic [SEED_WIDTH-1:0] exp_seed;
    push_words(32'hC0, 4);
    push_words(32'h31, 3);
    enable = 1'b1;
    repeat (8) step();
    checks++; if (state_dbg !== 3'd2) $display("FAIL drop_collecting: got %0d want 2", state_dbg); else passes++;
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passes++;
    step();
    checks++; if (state_dbg !== 3'd0) $display("FAIL drop_idle_hold: got %0d want 0", state_dbg); else passes++;
    push_words(32'hD0, 4);
    push_words(32'h41, 8);
    src_q.push_back(32'h49);
    exp_q.push_back(seed_of(32'h40));
    enable = 1'b1;
    seed_ready = 1'b0;
    repeat (13) step();
    exp_seed = exp_q.pop_front();
    checks++; if (seed_valid !== 1'b1) $display("FAIL drop_reseed_valid: got %b want 1", seed_valid); else passes++;
    checks++; if (seed_data !== exp_seed) $display("FAIL drop_reseed: got %h want %h", seed_data, exp_seed); else passes++;
    checks++; if (src_q.size() !== 1) $display("FAIL drop_words_used: got %0d left want 1", src_q.size()); else passes++;
    seed_ready = 1'b1;
    enable = 1'b0;
    step();
    seed_ready = 1'b0;
    src_q.delete();
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    repeat (4) src_q.push_back(32'hCC);
    repeat (5) step();
    exp_fail = (exp_fail == 8'hFF) ? 8'hFF : exp_fail + 8'd1;
    checks++; if (health_fail !== 1'b1) $display("FAIL sat_first_alarm: got %b want 1", health_fail); else passes++;
    checks++; if (fail_count !== exp_fail) $display("FAIL sat_first_count: got %0d want %0d", fail_count, exp_fail); else passes++;
    for (int i = 1; i < 256; i++) begin
      repeat (4) src_q.push_back(32'hCC);
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
      repeat (4) step();
      exp_fail = (exp_fail == 8'hFF) ? 8'hFF : exp_fail + 8'd1;
      checks++; if (fail_count !== exp_fail) $display("FAIL sat_count_%0d: got %0d want %0d", i, fail_count, exp_fail); else passes++;
    end
    checks++; if (fail_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", fail_count); else passes++;
    push_words(32'hE0, 4);
    push_words(32'h51, 8);
    src_q.push_back(32'h59);
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    repeat (12) step();
    checks++; if (seed_valid !== 1'b1) $display("FAIL sat_present: got %b want 1", seed_valid); else passes++;
    checks++; if (health_fail !== 1'b0) $display("FAIL sat_cleared: got %b want 0", health_fail); else passes++;
    rst = 1'b1;
    step();
    checks++; if (seed_valid !== 1'b0) $display("FAIL rst_seed_valid: got %b want 0", seed_valid); else passes++;
    checks++; if (seed_data !== '0) $display("FAIL rst_seed_data: got %h want 0", seed_data); else passes++;
    checks++; if (health_fail !== 1'b0) $display("FAIL rst_health_fail: got %b want 0", health_fail); else passes++;
    checks++; if (fail_count !== 8'd0) $display("FAIL rst_fail_count: got %0d want 0", fail_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
    checks++; if (src_pop !== 1'b0) $display("FAIL rst_src_pop: got %b want 0", src_pop); else passes++;
    rst = 1'b0;
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL rst_release_idle: got %b want 0", busy); else passes++;
    src_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_rct();
    test_apt();
    test_enable_drop();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
